button_debouncer: RTL and testbench
===================================

# button_debouncer

Cleans one raw push-button input of the alarm clock (hour/minute set, alarm on/off) into a stable, glitch-free level. The block sits directly upstream of the rising-edge detector. Its `level` output drives the detector's `LEVEL` input, so each physical press yields exactly one single-cycle pulse downstream. It synchronises the asynchronous pin into the `clk` domain, then accepts a new level only after it has been stable for a programmable number of consecutive cycles.

## Interface
- `DEBOUNCE_CYCLES`, default 500000 (10 ms at 50 MHz): number of consecutive synchronised samples required to accept a level change; legal range ≥ 2.
- `clk`  input  1: system clock; all state updates on rising edge.
- `rst`  input  1: reset, asynchronous, active-low.
- `btn_raw`  input  1: raw button pin, asynchronous to `clk`, may bounce.
- `level`  output  1: debounced level; registered, no combinational path from `btn_raw`.

## Operation
- Synchroniser: two flops, `s1 <= btn_raw`, `s2 <= s1`; both reset to 0. Only `s2` is used downstream of the synchroniser.
- Counter `cnt`: width `CNT_W = clog2(DEBOUNCE_CYCLES+1)`, local constant, resets to 0. It counts consecutive samples in the check states, saturates never (bounded by the FSM), and is cleared on every state change.
- FSM states: LOW, RISE_CHK, HIGH, FALL_CHK. Reset state is LOW.
- LOW:
  - `s2`=1 → RISE_CHK with `cnt`=1.
  - Otherwise stay.
- RISE_CHK:
  - `s2`=0 → LOW, `cnt`=0. This is a bounce, discarded.
  - `s2`=1 and `cnt`=DEBOUNCE_CYCLES-1 → HIGH, `cnt`=0.
  - Otherwise `cnt`+1.
- HIGH:
  - `s2`=0 → FALL_CHK with `cnt`=1.
  - Otherwise stay.
- FALL_CHK:
  - `s2`=1 → HIGH, `cnt`=0.
  - `s2`=0 and `cnt`=DEBOUNCE_CYCLES-1 → LOW, `cnt`=0.
  - Otherwise `cnt`+1.
- `level` is a registered output: 1 in HIGH and FALL_CHK, 0 in LOW and RISE_CHK. It never toggles during a check state.
- Unused encodings recover to LOW on the next edge.

## Timing
- Reset values: `s1`=0, `s2`=0, `cnt`=0, state=LOW, `level`=0. Reset takes effect immediately and asynchronously; the FSM leaves reset on the first rising edge after `rst` goes high.
- Edge numbering: edge 1 is the first edge that samples a new `btn_raw` value into `s1`.
- Latency: with `btn_raw` held stable from edge 1 on, `level` changes after edge DEBOUNCE_CYCLES+2. The path is 2 synchroniser edges plus DEBOUNCE_CYCLES FSM samples.
- Glitch rejection: any `s2` excursion shorter than DEBOUNCE_CYCLES samples produces no change on `level`. After a rejected excursion, a later change needs a full fresh DEBOUNCE_CYCLES count.
- Reset mid-check: state returns to LOW, `cnt`=0, `level`=0 at once. This holds even if `level` was 1.
- `btn_raw` high through reset release: treated as a fresh press. `level` rises DEBOUNCE_CYCLES+2 edges after release; downstream then sees one edge pulse.
- Maximum `level` toggle rate is one change per DEBOUNCE_CYCLES cycles.

## Structure
- Shared alarm constants header holds the debouncer state encodings (LOW=2'b00, RISE_CHK=2'b01, HIGH=2'b10, FALL_CHK=2'b11) and the default DEBOUNCE_CYCLES. All button channels share these.
- One sub-module: `sync_2ff`, a 1-bit two-flop synchroniser with async active-low reset to 0. It is reusable for the other asynchronous inputs of the alarm design.
- The top level instantiates one `button_debouncer` per button, each feeding its own rising-edge detector.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold `rst`=0 with `btn_raw`=1 for 10 cycles → `level`=0 throughout, and state=LOW.
- Clean press: `btn_raw` 0→1 before edge 1, held → `level` rises after edge 6. Downstream edge detector emits exactly one `Z` pulse.
- Bounced press: `btn_raw` high 2 cycles, low 1, high 3, low 1, then high steady → `level` stays 0 during the bounce. It rises 6 edges after the final 0→1.
- Bounced release from HIGH: `btn_raw` low 3 cycles, high 1, then low steady → `level` stays 1 through the bounce. It falls 6 edges after the final 1→0.
- Reset mid-check: assert `rst` while in RISE_CHK with `cnt`=2 → `level`=0 and state LOW immediately. After release with `btn_raw`=1, `level` rises 6 edges later.
- Back-to-back presses: 8-cycle high, 8-cycle low, 8-cycle high → `level` produces two distinct high periods, each delayed 6 edges. Two `Z` pulses result.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared constants for the alarm-clock button channels: debouncer state
// encodings and the default debounce window.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_LOW      = 2'b00,
    ST_RISE_CHK = 2'b01,
    ST_HIGH     = 2'b10,
    ST_FALL_CHK = 2'b11
  } deb_state_t;

  // 10 ms at 50 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

  // The accepted level is high once a rise is confirmed and stays high while a
  // fall is still being checked.
  function automatic logic level_of(input deb_state_t s);
    return (s == ST_HIGH) || (s == ST_FALL_CHK);
  endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// 1-bit two-flop synchroniser for asynchronous inputs of the alarm design.
// Both stages clear to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw push-button pin into a stable registered level that feeds
// the downstream rising-edge detector.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_s2;
  deb_state_t       r_state;
  deb_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_level;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (btn_raw),
    .o_q (w_s2)
  );

  // The first differing sample already counts as one, so a change is accepted
  // on the DEBOUNCE_CYCLES-th consecutive sample.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_LOW: begin
        if (w_s2) begin
          w_state_next = ST_RISE_CHK;
          w_cnt_next   = CNT_ONE;
        end
      end
      ST_RISE_CHK: begin
        if (!w_s2) begin
          w_state_next = ST_LOW;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = ST_HIGH;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!w_s2) begin
          w_state_next = ST_FALL_CHK;
          w_cnt_next   = CNT_ONE;
        end
      end
      ST_FALL_CHK: begin
        if (w_s2) begin
          w_state_next = ST_HIGH;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = ST_LOW;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = ST_LOW;
        w_cnt_next   = '0;
      end
    endcase
  end

  // level is derived from the next state so it changes on the same edge the
  // FSM confirms a transition, without an extra cycle of lag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_level <= level_of(w_state_next);
    end
  end

  assign level = r_level;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4: reset cases by
// hand, press/release/bounce patterns from a vector table.
module tb_button_debouncer;

  logic clk;
  logic rst;
  logic btn_raw;
  logic level;

  button_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .level   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic btn;
    logic exp_level;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Model of the downstream rising-edge detector (plus a falling counterpart)
  logic level_q   = 1'b0;
  int   rise_cnt  = 0;
  int   fall_cnt  = 0;

  always @(posedge clk) begin
    level_q <= level;
    if (level && !level_q) rise_cnt <= rise_cnt + 1;
    if (!level && level_q) fall_cnt <= fall_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic add_vec(input logic b, input logic l, input int n);
    vec_t v;
    v.btn       = b;
    v.exp_level = l;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  int rise0;
  int fall0;

  initial begin
    // Clean press from LOW
    add_vec(1'b1, 1'b0, 5);
    add_vec(1'b1, 1'b1, 3);
    // Bounced release: low 3, high 1, low steady
    add_vec(1'b0, 1'b1, 3);
    add_vec(1'b1, 1'b1, 1);
    add_vec(1'b0, 1'b1, 5);
    add_vec(1'b0, 1'b0, 3);
    // Bounced press: high 2, low 1, high 3, low 1, high steady
    add_vec(1'b1, 1'b0, 2);
    add_vec(1'b0, 1'b0, 1);
    add_vec(1'b1, 1'b0, 3);
    add_vec(1'b0, 1'b0, 1);
    add_vec(1'b1, 1'b0, 5);
    add_vec(1'b1, 1'b1, 3);
    // Clean release back to LOW
    add_vec(1'b0, 1'b1, 5);
    add_vec(1'b0, 1'b0, 5);
    // Back-to-back: 8 high, 8 low, 8 high, then low
    add_vec(1'b1, 1'b0, 5);
    add_vec(1'b1, 1'b1, 3);
    add_vec(1'b0, 1'b1, 5);
    add_vec(1'b0, 1'b0, 3);
    add_vec(1'b1, 1'b0, 5);
    add_vec(1'b1, 1'b1, 3);
    add_vec(1'b0, 1'b1, 5);
    add_vec(1'b0, 1'b0, 5);

    // Reset held with button pressed
    rst     = 1'b0;
    btn_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("rst_level_c%0d", k), 32'(level), 32'd0);
      check($sformatf("rst_state_c%0d", k), 32'(dut.r_state), 32'd0);
    end

    // Button high through release is a fresh press: rises after edge 6
    @(negedge clk); rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("rel_press_e%0d", k), 32'(level), (k == 6) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset while level is high clears it without a clock edge
    @(negedge clk);
    btn_raw = 1'b0;
    rst     = 1'b0;
    #1;
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_state", 32'(dut.r_state), 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (4) @(negedge clk);
    rise0 = rise_cnt;
    fall0 = fall_cnt;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk); btn_raw = vecs[i].btn;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), 32'(level), 32'(vecs[i].exp_level));
    end
    @(posedge clk); #1;
    check("rise_pulses", 32'(rise_cnt - rise0), 32'd4);
    check("fall_edges", 32'(fall_cnt - fall0), 32'd4);

    // Reset mid-check: RISE_CHK with cnt=2, then release with button held
    @(negedge clk); btn_raw = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midchk_pre_state", 32'(dut.r_state), 32'd1);
    check("midchk_pre_cnt", 32'(dut.r_cnt), 32'd2);
    #1;
    rst = 1'b0;
    #1;
    check("midchk_level", 32'(level), 32'd0);
    check("midchk_state", 32'(dut.r_state), 32'd0);
    check("midchk_cnt", 32'(dut.r_cnt), 32'd0);
    @(negedge clk); rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("midchk_rel_e%0d", k), 32'(level), (k == 6) ? 32'd1 : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
